// File: rtl/s_trap_sequencer.sv
// Supervisor trap/return sequencer: arbitrates exceptions, SRET and gated
// supervisor interrupts, drains the pipeline, pulses the CSR file and issues
// one PC/mode redirect per accepted event.
module s_trap_sequencer #(
    parameter int unsigned DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            current_mode,
    input  logic                  s_ie,
    input  logic                  irq_ssi,
    input  logic                  irq_sti,
    input  logic                  irq_sei,
    input  logic                  exc_valid,
    input  logic [3:0]            exc_code,
    input  logic [DATA_WIDTH-1:0] exc_tval,
    input  logic [DATA_WIDTH-1:0] exc_pc,
    input  logic                  sret_req,
    input  logic [DATA_WIDTH-1:0] instr_pc,
    input  logic [DATA_WIDTH-1:0] stvec,
    input  logic [DATA_WIDTH-1:0] return_pc,
    input  logic [1:0]            return_mode,
    input  logic                  flush_ack,
    output logic                  req_ack,
    output logic                  flush_req,
    output logic                  csr_exception,
    output logic [3:0]            csr_exception_code,
    output logic [DATA_WIDTH-1:0] csr_exception_value,
    output logic [DATA_WIDTH-1:0] csr_exception_pc,
    output logic                  csr_return,
    output logic                  redirect_valid,
    output logic [DATA_WIDTH-1:0] redirect_pc,
    output logic [1:0]            redirect_mode,
    output logic                  busy
);

    typedef enum logic [2:0] {
        StIdle,
        StTFlush,
        StTEnter,
        StTVector,
        StRFlush,
        StRReturn,
        StRVector
    } state_e;

    state_e                state_q, state_d;
    logic [3:0]            code_q, code_d;
    logic [DATA_WIDTH-1:0] tval_q, tval_d;
    logic [DATA_WIDTH-1:0] pc_q, pc_d;
    logic                  irq_q, irq_d;
    logic [3:0]            vidx_q, vidx_d;
    logic [DATA_WIDTH-1:0] ret_pc_q, ret_pc_d;
    logic [1:0]            ret_mode_q, ret_mode_d;

    logic                  irq_ok;
    logic [DATA_WIDTH-1:0] vec_base;
    logic [DATA_WIDTH-1:0] vec_off;

    // Supervisor interrupts are only taken from U-mode, or S-mode with SIE set.
    assign irq_ok = (current_mode == 2'b00) || ((current_mode == 2'b01) && s_ie);

    // State and capture registers; reset abandons any trap in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            code_q     <= '0;
            tval_q     <= '0;
            pc_q       <= '0;
            irq_q      <= 1'b0;
            vidx_q     <= '0;
            ret_pc_q   <= '0;
            ret_mode_q <= '0;
        end else begin
            state_q    <= state_d;
            code_q     <= code_d;
            tval_q     <= tval_d;
            pc_q       <= pc_d;
            irq_q      <= irq_d;
            vidx_q     <= vidx_d;
            ret_pc_q   <= ret_pc_d;
            ret_mode_q <= ret_mode_d;
        end
    end

    // Next-state, event arbitration in IDLE and capture of the accepted event.
    always_comb begin
        state_d    = state_q;
        code_d     = code_q;
        tval_d     = tval_q;
        pc_d       = pc_q;
        irq_d      = irq_q;
        vidx_d     = vidx_q;
        ret_pc_d   = ret_pc_q;
        ret_mode_d = ret_mode_q;
        req_ack    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (exc_valid) begin
                    req_ack = 1'b1;
                    code_d  = exc_code;
                    tval_d  = exc_tval;
                    pc_d    = exc_pc;
                    irq_d   = 1'b0;
                    vidx_d  = '0;
                    state_d = StTFlush;
                end else if (sret_req) begin
                    req_ack = 1'b1;
                    state_d = StRFlush;
                end else if (irq_ok && (irq_sei || irq_ssi || irq_sti)) begin
                    // Interrupts are not request/ack handshaked; they are just sampled.
                    irq_d   = 1'b1;
                    tval_d  = '0;
                    pc_d    = instr_pc;
                    state_d = StTFlush;
                    if (irq_sei) begin
                        code_d = 4'hB;
                        vidx_d = 4'd9;
                    end else if (irq_ssi) begin
                        code_d = 4'h9;
                        vidx_d = 4'd1;
                    end else begin
                        code_d = 4'hD;
                        vidx_d = 4'd5;
                    end
                end
            end
            StTFlush:  if (flush_ack) state_d = StTEnter;
            StTEnter:  state_d = StTVector;
            StTVector: state_d = StIdle;
            StRFlush:  if (flush_ack) state_d = StRReturn;
            StRReturn: begin
                // Latch the return target before the CSR file rewrites SPP.
                ret_pc_d   = return_pc;
                ret_mode_d = return_mode;
                state_d    = StRVector;
            end
            StRVector: state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    assign vec_base = {stvec[DATA_WIDTH-1:2], 2'b00};
    assign vec_off  = {{(DATA_WIDTH-6){1'b0}}, vidx_q, 2'b00};

    // Outputs decoded from registered state and captured fields.
    always_comb begin
        flush_req           = (state_q == StTFlush) || (state_q == StRFlush);
        csr_exception       = (state_q == StTEnter);
        csr_return          = (state_q == StRReturn);
        csr_exception_code  = code_q;
        csr_exception_value = tval_q;
        csr_exception_pc    = pc_q;
        busy                = (state_q != StIdle);
        redirect_valid      = 1'b0;
        redirect_pc         = '0;
        redirect_mode       = 2'b00;
        if (state_q == StTVector) begin
            redirect_valid = 1'b1;
            redirect_mode  = 2'b01;
            // Vectored mode only offsets interrupts; modes 10/11 behave as direct.
            redirect_pc    = (irq_q && (stvec[1:0] == 2'b01)) ? (vec_base + vec_off) : vec_base;
        end else if (state_q == StRVector) begin
            redirect_valid = 1'b1;
            redirect_pc    = ret_pc_q;
            redirect_mode  = ret_mode_q;
        end
    end

endmodule

// File: tb/tb_s_trap_sequencer.sv
// Self-checking bench for s_trap_sequencer: directed cases plus randomized
// transactions checked against a timeline-level reference model.
module tb_s_trap_sequencer;

    localparam int DW = 64;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [1:0]    current_mode = '0;
    logic          s_ie = 1'b0;
    logic          irq_ssi = 1'b0, irq_sti = 1'b0, irq_sei = 1'b0;
    logic          exc_valid = 1'b0;
    logic [3:0]    exc_code = '0;
    logic [DW-1:0] exc_tval = '0, exc_pc = '0;
    logic          sret_req = 1'b0;
    logic [DW-1:0] instr_pc = '0, stvec = '0, return_pc = '0;
    logic [1:0]    return_mode = '0;
    logic          flush_ack = 1'b0;
    logic          req_ack, flush_req, csr_exception, csr_return, redirect_valid, busy;
    logic [3:0]    csr_exception_code;
    logic [DW-1:0] csr_exception_value, csr_exception_pc, redirect_pc;
    logic [1:0]    redirect_mode;

    int n_cmp = 0;
    int n_err = 0;

    s_trap_sequencer #(.DATA_WIDTH(DW)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .current_mode        (current_mode),
        .s_ie                (s_ie),
        .irq_ssi             (irq_ssi),
        .irq_sti             (irq_sti),
        .irq_sei             (irq_sei),
        .exc_valid           (exc_valid),
        .exc_code            (exc_code),
        .exc_tval            (exc_tval),
        .exc_pc              (exc_pc),
        .sret_req            (sret_req),
        .instr_pc            (instr_pc),
        .stvec               (stvec),
        .return_pc           (return_pc),
        .return_mode         (return_mode),
        .flush_ack           (flush_ack),
        .req_ack             (req_ack),
        .flush_req           (flush_req),
        .csr_exception       (csr_exception),
        .csr_exception_code  (csr_exception_code),
        .csr_exception_value (csr_exception_value),
        .csr_exception_pc    (csr_exception_pc),
        .csr_return          (csr_return),
        .redirect_valid      (redirect_valid),
        .redirect_pc         (redirect_pc),
        .redirect_mode       (redirect_mode),
        .busy                (busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Trap target from the stvec rules: base, plus 4*index for vectored interrupts.
    function automatic logic [DW-1:0] exp_target(input logic [DW-1:0] stv, input bit is_irq,
                                                 input logic [3:0] code);
        logic [DW-1:0] base;
        int idx;
        base = stv & ~64'h3;
        idx  = (code == 4'h9) ? 1 : (code == 4'hD) ? 5 : 9;
        if (is_irq && stv[1:0] == 2'b01) return base + 64'(4 * idx);
        return base;
    endfunction

    // Drives one IDLE-sampled scenario and follows the expected timeline to completion.
    // d = number of flush cycles with flush_ack low.
    task automatic run_txn(input logic [1:0] mode, input bit sie, input bit ssi, input bit sti,
                           input bit sei, input bit ev, input logic [3:0] ecode,
                           input logic [DW-1:0] etval, input logic [DW-1:0] epc, input bit sr,
                           input logic [DW-1:0] ipc, input logic [DW-1:0] stv,
                           input logic [DW-1:0] rpc, input logic [1:0] rmode, input int d);
        int kind;  // 0 none, 1 exception, 2 sret, 3 interrupt
        bit elig;
        logic [3:0] e_code;
        logic [DW-1:0] e_tval, e_pc;
        current_mode = mode; s_ie = sie; irq_ssi = ssi; irq_sti = sti; irq_sei = sei;
        exc_valid = ev; exc_code = ecode; exc_tval = etval; exc_pc = epc; sret_req = sr;
        instr_pc = ipc; stvec = stv; return_pc = rpc; return_mode = rmode; flush_ack = 1'b0;

        elig = (mode == 2'b00) || (mode == 2'b01 && sie);
        e_code = ecode; e_tval = etval; e_pc = epc;
        if (ev) kind = 1;
        else if (sr) kind = 2;
        else if (elig && (ssi || sti || sei)) begin
            kind = 3; e_tval = '0; e_pc = ipc;
            e_code = sei ? 4'hB : ssi ? 4'h9 : 4'hD;
        end else kind = 0;

        @(negedge clk);
        check_eq("idle_busy", busy, 0);
        check_eq("req_ack", req_ack, (kind == 1 || kind == 2));
        tick();
        if (kind == 0) begin
            check_eq("stay_idle", busy, 0);
            return;
        end
        if (kind == 1) exc_valid = 1'b0;
        if (kind == 2) sret_req = 1'b0;

        for (int k = 0; k <= d; k++) begin
            flush_ack = (k == d);
            irq_ssi = 1'($urandom); irq_sti = 1'($urandom); irq_sei = 1'($urandom);
            stvec = {$urandom, $urandom};
            @(negedge clk);
            check_eq("flush_req", flush_req, 1);
            check_eq("flush_busy", busy, 1);
            check_eq("flush_noack", req_ack, 0);
            check_eq("flush_quiet", {csr_exception, csr_return, redirect_valid}, 0);
            tick();
        end
        flush_ack = 1'b0;

        @(negedge clk);
        check_eq("flush_drop", flush_req, 0);
        if (kind != 2) begin
            check_eq("csr_exc", csr_exception, 1);
            check_eq("csr_ret_n", csr_return, 0);
            check_eq("exc_code", csr_exception_code, e_code);
            check_eq("exc_value", csr_exception_value, e_tval);
            check_eq("exc_pc", csr_exception_pc, e_pc);
        end else begin
            check_eq("csr_ret", csr_return, 1);
            check_eq("csr_exc_n", csr_exception, 0);
        end
        tick();
        // CSR file has updated: return state moves, stvec settles for sampling.
        return_pc = {$urandom, $urandom};
        return_mode = 2'b00;
        stvec = stv;

        @(negedge clk);
        check_eq("redir_valid", redirect_valid, 1);
        check_eq("redir_noack", req_ack, 0);
        check_eq("redir_pulses", {csr_exception, csr_return, flush_req}, 0);
        if (kind != 2) begin
            check_eq("redir_pc", redirect_pc, exp_target(stv, kind == 3, e_code));
            check_eq("redir_mode", redirect_mode, 2'b01);
        end else begin
            check_eq("ret_pc", redirect_pc, rpc);
            check_eq("ret_mode", redirect_mode, rmode);
        end
        tick();
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_ctl"}, {req_ack, flush_req, csr_exception, csr_return,
                                 redirect_valid, busy}, 0);
        check_eq({tag, "_code"}, csr_exception_code, 0);
        check_eq({tag, "_val"}, csr_exception_value, 0);
        check_eq({tag, "_pc"}, csr_exception_pc, 0);
        check_eq({tag, "_rpc"}, redirect_pc, 0);
        check_eq({tag, "_rmode"}, redirect_mode, 0);
    endtask

    initial begin
        bit pend;
        bit ev, sr;
        #12;
        check_all_zero("reset");
        @(posedge clk); #1 rst_n = 1'b1;
        tick();

        // Directed cases
        run_txn(2'b00, 0, 0, 0, 0, 1, 4'h2, 64'hDEAD, 64'h8000_0100, 0, 0, 64'h8000_2001,
                0, 0, 0);
        run_txn(2'b01, 1, 0, 1, 1, 0, 0, 0, 0, 0, 64'h400, 64'h8000_2001, 0, 0, 0);
        run_txn(2'b01, 0, 1, 0, 0, 0, 0, 0, 0, 0, 64'h500, 64'h8000_2001, 0, 0, 0);
        run_txn(2'b00, 0, 1, 0, 0, 0, 0, 0, 0, 0, 64'h500, 64'h8000_2001, 0, 0, 0);
        run_txn(2'b11, 1, 1, 1, 1, 0, 0, 0, 0, 0, 64'h500, 64'h8000_2001, 0, 0, 0);
        run_txn(2'b01, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 64'h8000_2001, 64'h1234, 2'b01, 0);
        run_txn(2'b01, 1, 0, 0, 0, 1, 4'h5, 64'h77, 64'h88, 1, 0, 64'hFFFF_FFFF_FFFF_FFFD,
                64'h1234, 2'b01, 3);
        run_txn(2'b01, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 64'h8000_2001, 64'h5678, 2'b01, 1);

        // Reset while draining abandons the trap
        current_mode = 2'b00; exc_valid = 1'b1; exc_code = 4'h7; exc_tval = 64'h1;
        exc_pc = 64'h2; sret_req = 1'b0; irq_ssi = 0; irq_sti = 0; irq_sei = 0;
        flush_ack = 1'b0;
        tick();
        exc_valid = 1'b0;
        @(negedge clk);
        check_eq("pre_rst_flush", flush_req, 1);
        #1 rst_n = 1'b0;
        #1 check_all_zero("mid_rst");
        @(posedge clk); #1 rst_n = 1'b1; flush_ack = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("post_rst_quiet", {csr_exception, redirect_valid, busy}, 0);
            tick();
        end
        flush_ack = 1'b0;

        // Randomized transactions
        pend = 0;
        for (int t = 0; t < 300; t++) begin
            ev = ($urandom_range(0, 2) == 0);
            sr = pend || ($urandom_range(0, 3) == 0);
            run_txn(2'($urandom), 1'($urandom), ($urandom_range(0, 2) == 0),
                    ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0), ev,
                    4'($urandom), {$urandom, $urandom}, {$urandom, $urandom}, sr,
                    {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
                    2'($urandom), $urandom_range(0, 3));
            pend = ev && sr;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
